// File: rtl/cpu_parameters.sv
// Shared CPU constants, issue FSM state encoding and the decoded-instruction slot layout.
package cpu_parameters;

  localparam int unsigned xlen   = 32;
  localparam int unsigned UOP_W  = 8;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    ISS_EMPTY = 1'b0,
    ISS_HELD  = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [xlen-1:0]   pc;
    logic [UOP_W-1:0]  uop;
    logic [xlen-1:0]   imm;
    logic              rs1_v;
    logic [REG_AW-1:0] rs1;
    logic              rs2_v;
    logic [REG_AW-1:0] rs2;
    logic              rd_v;
    logic [REG_AW-1:0] rd;
  } issue_uop_t;

endpackage

// File: rtl/issue_stage.sv
// Issue stage: holds one decoded instruction, reads operands, waits for hazards
// to clear and execute to accept, then issues into the execute pipeline register.
module issue_stage
  import cpu_parameters::*;
#(
  parameter int unsigned XLEN  = cpu_parameters::xlen,
  parameter int unsigned UOP_W = cpu_parameters::UOP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [XLEN-1:0]  dec_pc,
  input  logic [UOP_W-1:0] dec_uop,
  input  logic [XLEN-1:0]  dec_imm,
  input  logic             dec_rs1_v,
  input  logic [4:0]       dec_rs1,
  input  logic             dec_rs2_v,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rd_v,
  input  logic [4:0]       dec_rd,
  output logic             rf_r0_valid,
  output logic [4:0]       rf_r0_ad,
  output logic             rf_r1_valid,
  output logic [4:0]       rf_r1_ad,
  input  logic [XLEN-1:0]  rf_r0_data,
  input  logic [XLEN-1:0]  rf_r1_data,
  input  logic             rf_r_v,
  output logic             rf_block_rd,
  output logic [4:0]       rf_rd,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [UOP_W-1:0] ex_uop,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic             ex_rd_v,
  output logic [4:0]       ex_rd,
  output logic [31:0]      stall_cnt
);

  localparam int unsigned CNT_W = 32;

  issue_state_t     state_q, state_d;
  issue_uop_t       slot_q;
  logic             held;
  logic             fire;
  logic             accept;

  logic             ex_valid_q;
  logic [XLEN-1:0]  ex_pc_q, ex_imm_q, ex_op1_q, ex_op2_q;
  logic [UOP_W-1:0] ex_uop_q;
  logic             ex_rd_v_q;
  logic [4:0]       ex_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Handshake terms: issue needs clean sources and a free or draining output register
  always_comb begin
    held      = (state_q == ISS_HELD);
    fire      = held & rf_r_v & (~ex_valid_q | ex_ready) & ~flush;
    dec_ready = ~flush & (~held | fire);
    accept    = dec_valid & dec_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ISS_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush dominates from any state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ISS_EMPTY;
    end else begin
      case (state_q)
        ISS_EMPTY: if (accept)         state_d = ISS_HELD;
        ISS_HELD:  if (fire & ~accept) state_d = ISS_EMPTY;
        default:                       state_d = ISS_EMPTY;
      endcase
    end
  end

  // Held instruction slot, loaded on every accepted decode handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (accept) begin
      slot_q.pc    <= xlen'(dec_pc);
      slot_q.uop   <= cpu_parameters::UOP_W'(dec_uop);
      slot_q.imm   <= xlen'(dec_imm);
      slot_q.rs1_v <= dec_rs1_v;
      slot_q.rs1   <= dec_rs1;
      slot_q.rs2_v <= dec_rs2_v;
      slot_q.rs2   <= dec_rs2;
      slot_q.rd_v  <= dec_rd_v;
      slot_q.rd    <= dec_rd;
    end
  end

  // Register-file read and scoreboard requests straight from the held slot
  always_comb begin
    rf_r0_valid = held & slot_q.rs1_v;
    rf_r0_ad    = held ? slot_q.rs1 : 5'd0;
    rf_r1_valid = held & slot_q.rs2_v;
    rf_r1_ad    = held ? slot_q.rs2 : 5'd0;
    rf_rd       = slot_q.rd;
    rf_block_rd = fire & slot_q.rd_v & (slot_q.rd != 5'd0);
  end

  // Execute valid: set on issue, dropped when consumed with nothing behind it or on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ex_valid_q <= 1'b0;
    else if (flush)    ex_valid_q <= 1'b0;
    else if (fire)     ex_valid_q <= 1'b1;
    else if (ex_ready) ex_valid_q <= 1'b0;
  end

  // Execute payload, replaced in place on issue; unused sources read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_q   <= '0;
      ex_imm_q  <= '0;
      ex_uop_q  <= '0;
      ex_op1_q  <= '0;
      ex_op2_q  <= '0;
      ex_rd_v_q <= 1'b0;
      ex_rd_q   <= '0;
    end else if (fire) begin
      ex_pc_q   <= XLEN'(slot_q.pc);
      ex_imm_q  <= XLEN'(slot_q.imm);
      ex_uop_q  <= UOP_W'(slot_q.uop);
      ex_op1_q  <= slot_q.rs1_v ? rf_r0_data : '0;
      ex_op2_q  <= slot_q.rs2_v ? rf_r1_data : '0;
      ex_rd_v_q <= slot_q.rd_v;
      ex_rd_q   <= slot_q.rd;
    end
  end

  // Saturating count of held cycles that did not issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (held & ~fire & ~flush & (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_pc     = ex_pc_q;
  assign ex_imm    = ex_imm_q;
  assign ex_uop    = ex_uop_q;
  assign ex_op1    = ex_op1_q;
  assign ex_op2    = ex_op2_q;
  assign ex_rd_v   = ex_rd_v_q;
  assign ex_rd     = ex_rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: scoreboard of expected execute payloads
// plus directed checks of hazard, backpressure, x0, flush and async reset.
module tb_issue_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned UOP_W = 8;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [UOP_W-1:0] uop;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             rd_v;
    logic [4:0]       rd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             dec_valid = 1'b0;
  logic             dec_ready;
  logic [XLEN-1:0]  dec_pc = '0;
  logic [UOP_W-1:0] dec_uop = '0;
  logic [XLEN-1:0]  dec_imm = '0;
  logic             dec_rs1_v = 1'b0;
  logic [4:0]       dec_rs1 = '0;
  logic             dec_rs2_v = 1'b0;
  logic [4:0]       dec_rs2 = '0;
  logic             dec_rd_v = 1'b0;
  logic [4:0]       dec_rd = '0;
  logic             rf_r0_valid, rf_r1_valid;
  logic [4:0]       rf_r0_ad, rf_r1_ad;
  logic [XLEN-1:0]  rf_r0_data, rf_r1_data;
  logic             rf_r_v = 1'b1;
  logic             rf_block_rd;
  logic [4:0]       rf_rd;
  logic             ex_valid;
  logic             ex_ready = 1'b1;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_op1, ex_op2;
  logic [UOP_W-1:0] ex_uop;
  logic             ex_rd_v;
  logic [4:0]       ex_rd;
  logic [31:0]      stall_cnt;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  issue_stage #(.XLEN(XLEN), .UOP_W(UOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_uop(dec_uop), .dec_imm(dec_imm),
    .dec_rs1_v(dec_rs1_v), .dec_rs1(dec_rs1),
    .dec_rs2_v(dec_rs2_v), .dec_rs2(dec_rs2),
    .dec_rd_v(dec_rd_v), .dec_rd(dec_rd),
    .rf_r0_valid(rf_r0_valid), .rf_r0_ad(rf_r0_ad),
    .rf_r1_valid(rf_r1_valid), .rf_r1_ad(rf_r1_ad),
    .rf_r0_data(rf_r0_data), .rf_r1_data(rf_r1_data),
    .rf_r_v(rf_r_v), .rf_block_rd(rf_block_rd), .rf_rd(rf_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_uop(ex_uop),
    .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd_v(ex_rd_v), .ex_rd(ex_rd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file contents seen by the stage
  function automatic logic [XLEN-1:0] regval(input logic [4:0] i);
    case (i)
      5'd3:    regval = 32'd5;
      5'd4:    regval = 32'd7;
      default: regval = 32'h100 + 32'(i) * 32'd3;
    endcase
  endfunction

  assign rf_r0_data = regval(rf_r0_ad);
  assign rf_r1_data = regval(rf_r1_ad);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one instruction, wait (bounded) for acceptance, push its expected result
  task automatic send(input logic [31:0] pc, input logic [7:0] uop, input logic [31:0] imm,
                      input logic r1v, input logic [4:0] r1, input logic r2v, input logic [4:0] r2,
                      input logic rdv, input logic [4:0] rd);
    exp_t e;
    bit   ok = 0;
    @(posedge clk); #1;
    dec_pc = pc; dec_uop = uop; dec_imm = imm;
    dec_rs1_v = r1v; dec_rs1 = r1; dec_rs2_v = r2v; dec_rs2 = r2;
    dec_rd_v = rdv; dec_rd = rd; dec_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dec_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    e.pc = pc; e.uop = uop; e.imm = imm;
    e.op1 = r1v ? regval(r1) : '0;
    e.op2 = r2v ? regval(r2) : '0;
    e.rd_v = rdv; e.rd = rd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    dec_valid = 1'b0;
  endtask

  // Scoreboard: compare each consumed execute payload against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready && !flush) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_issue", 64'(ex_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ex_pc",   64'(ex_pc),   64'(e.pc));
        chk("ex_uop",  64'(ex_uop),  64'(e.uop));
        chk("ex_imm",  64'(ex_imm),  64'(e.imm));
        chk("ex_op1",  64'(ex_op1),  64'(e.op1));
        chk("ex_op2",  64'(ex_op2),  64'(e.op2));
        chk("ex_rd_v", 64'(ex_rd_v), 64'(e.rd_v));
        chk("ex_rd",   64'(ex_rd),   64'(e.rd));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [31:0] saved_pc;

  initial begin
    // Reset state
    #12;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_stall",    64'(stall_cnt), 64'd0);
    chk("rst_dec_rdy",  64'(dec_ready), 64'd1);
    chk("rst_block",    64'(rf_block_rd), 64'd0);
    chk("rst_ex_pc",    64'(ex_pc), 64'd0);
    chk("rst_r0_valid", 64'(rf_r0_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // No hazard: x3=5, x4=7 into rd=6, issued the cycle after accept
    send(32'h1000, 8'h11, 32'h44, 1, 5'd3, 1, 5'd4, 1, 5'd6);
    @(negedge clk);
    chk("nh_block",  64'(rf_block_rd), 64'd1);
    chk("nh_rf_rd",  64'(rf_rd), 64'd6);
    chk("nh_r0_ad",  64'(rf_r0_ad), 64'd3);
    chk("nh_r1_ad",  64'(rf_r1_ad), 64'd4);
    @(negedge clk);
    chk("nh_ex_valid", 64'(ex_valid), 64'd1);
    drain();

    // Hazard for three cycles, then release
    rf_r_v = 1'b0;
    send(32'h2000, 8'h22, 32'h5, 1, 5'd1, 0, 5'd9, 1, 5'd2);
    @(negedge clk);
    chk("hz_dec_rdy", 64'(dec_ready), 64'd0);
    chk("hz_block",   64'(rf_block_rd), 64'd0);
    chk("hz_r0_v",    64'(rf_r0_valid), 64'd1);
    repeat (3) @(negedge clk);
    chk("hz_stall3",  64'(stall_cnt), 64'd3);
    chk("hz_no_ex",   64'(ex_valid), 64'd0);
    @(posedge clk); #1; rf_r_v = 1'b1;
    @(negedge clk);
    chk("hz_fire_block", 64'(rf_block_rd), 64'd1);
    drain();
    chk("hz_stall_hold", 64'(stall_cnt), 64'd4);

    // Backpressure: second instruction waits, ex payload frozen, then back-to-back
    @(posedge clk); #1; ex_ready = 1'b0;
    send(32'h3000, 8'h33, 32'h1, 1, 5'd7, 1, 5'd8, 1, 5'd9);
    send(32'h3004, 8'h34, 32'h2, 0, 5'd0, 1, 5'd3, 1, 5'd10);
    @(negedge clk);
    saved_pc = ex_pc;
    chk("bp_first_pc", 64'(saved_pc), 64'h3000);
    repeat (3) @(negedge clk);
    chk("bp_pc_stable", 64'(ex_pc), 64'h3000);
    chk("bp_valid",     64'(ex_valid), 64'd1);
    chk("bp_dec_rdy",   64'(dec_ready), 64'd0);
    chk("bp_no_block",  64'(rf_block_rd), 64'd0);
    @(posedge clk); #1; ex_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_b2b_valid", 64'(ex_valid), 64'd1);
    chk("bp_b2b_pc",    64'(ex_pc), 64'h3004);
    drain();

    // rd = x0 issues but never marks busy
    send(32'h4000, 8'h44, 32'h0, 1, 5'd4, 0, 5'd0, 1, 5'd0);
    @(negedge clk);
    chk("x0_block", 64'(rf_block_rd), 64'd0);
    drain();

    // Flush with an instruction held and another in the ex register
    @(posedge clk); #1; ex_ready = 1'b0;
    send(32'h5000, 8'h55, 32'h3, 1, 5'd5, 0, 5'd0, 1, 5'd11);
    send(32'h5004, 8'h56, 32'h4, 1, 5'd6, 0, 5'd0, 1, 5'd12);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    chk("fl_dec_rdy", 64'(dec_ready), 64'd0);
    chk("fl_block",   64'(rf_block_rd), 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("fl_ex_valid", 64'(ex_valid), 64'd0);
    chk("fl_empty_r0", 64'(rf_r0_valid), 64'd0);
    chk("fl_dec_rdy1", 64'(dec_ready), 64'd1);
    chk("fl_block2",   64'(rf_block_rd), 64'd0);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());

    // Async reset mid-HELD, off the clock edge
    send(32'h6000, 8'h66, 32'h5, 1, 5'd2, 0, 5'd0, 1, 5'd13);
    send(32'h6004, 8'h67, 32'h6, 1, 5'd3, 0, 5'd0, 1, 5'd14);
    @(negedge clk); @(negedge clk);
    chk("ar_pre_stall", 64'(stall_cnt != 0), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("ar_ex_valid", 64'(ex_valid), 64'd0);
    chk("ar_stall",    64'(stall_cnt), 64'd0);
    chk("ar_empty",    64'(rf_r0_valid), 64'd0);
    sb_q.delete();
    @(posedge clk); #3; rst_n = 1'b1; ex_ready = 1'b1;
    @(negedge clk);
    chk("ar_dec_rdy",  64'(dec_ready), 64'd1);
    chk("ar_r0_after", 64'(rf_r0_valid), 64'd0);

    // Post-reset sanity transaction
    send(32'h7000, 8'h77, 32'h7, 1, 5'd3, 1, 5'd4, 1, 5'd6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
